// File: rtl/axi_master_txn_scheduler.sv
// Round-robin scheduler between NUM_REQ clients and an AXI master decoder.
// One outstanding write and one outstanding read, each with a response watchdog.
module axi_master_txn_scheduler #(
  parameter int addr_width = 32,
  parameter int data_width = 64,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           AClk,
  input  logic                           ARst,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*addr_width-1:0]  wr_addr,
  input  logic [NUM_REQ*8-1:0]           wr_len,
  input  logic [NUM_REQ*data_width-1:0]  wr_data,
  input  logic [NUM_REQ*data_width/8-1:0] wr_strb,
  output logic [NUM_REQ-1:0]             wr_gnt,
  output logic [NUM_REQ-1:0]             wr_done,
  output logic [1:0]                     wr_resp,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*addr_width-1:0]  rd_addr,
  input  logic [NUM_REQ*8-1:0]           rd_len,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [data_width-1:0]          rd_data,
  output logic [1:0]                     rd_resp,
  output logic [NUM_REQ-1:0]             rd_done,
  output logic                           id_err,
  output logic [3:0]                     TXN_ID_W_d,
  output logic [addr_width-1:0]          awaddr_d,
  output logic [7:0]                     awlen_d,
  output logic [2:0]                     awsize_d,
  output logic [1:0]                     awburst_d,
  output logic [1:0]                     awlock_d,
  output logic [1:0]                     awcache_d,
  output logic [2:0]                     awprot_d,
  output logic [data_width-1:0]          wdata_d,
  output logic [data_width/8-1:0]        wstrb_d,
  output logic                           wr_trn_en,
  output logic [3:0]                     TXN_ID_R_d,
  output logic [addr_width-1:0]          araddr_d,
  output logic [7:0]                     arlen_d,
  output logic [2:0]                     arsize_d,
  output logic [1:0]                     arburst_d,
  output logic [1:0]                     arlock_d,
  output logic [1:0]                     arcache_d,
  output logic [2:0]                     arprot_d,
  output logic                           rd_trn_en,
  input  logic [1:0]                     bresp_d,
  input  logic [3:0]                     bid_d,
  input  logic                           wr_rsp_en_d,
  input  logic [data_width-1:0]          rdata_d,
  input  logic [1:0]                     rresp_d,
  input  logic [7:0]                     rid_d,
  input  logic                           rd_rsp_en_d,
  input  logic                           r_last_d
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int SW = data_width / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [2:0] ASIZE = 3'($clog2(SW));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} st_e;

  // {hit, index}: first requester at or after ptr, wrapping
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IW-1:0]      ptr
  );
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx[IW-1:0]]) r = {1'b1, idx[IW-1:0]};
    end
    return r;
  endfunction

  st_e                  w_st_q, w_st_d, r_st_q, r_st_d;
  logic [IW-1:0]        w_own_q, w_own_d, r_own_q, r_own_d;
  logic [IW-1:0]        w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [CW-1:0]        w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [addr_width-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [7:0]           aw_len_q, aw_len_d, ar_len_q, ar_len_d;
  logic [3:0]           w_id_q, w_id_d, r_id_q, r_id_d;
  logic [NUM_REQ-1:0]   w_gnt_q, w_gnt_d, r_gnt_q, r_gnt_d;
  logic [NUM_REQ-1:0]   w_done_q, w_done_d, r_done_q, r_done_d;
  logic [NUM_REQ-1:0]   r_vld_q, r_vld_d;
  logic                 w_trn_q, w_trn_d, r_trn_q, r_trn_d;
  logic [1:0]           w_resp_q, w_resp_d, r_resp_q, r_resp_d;
  logic [data_width-1:0] r_data_q, r_data_d;
  logic                 id_err_q, id_err_d;
  logic                 w_ierr, r_ierr;
  logic [IW:0]          w_pick, r_pick;
  logic [NUM_REQ-1:0]   w_oh, r_oh;

  assign w_oh = NUM_REQ'(1) << w_own_q;
  assign r_oh = NUM_REQ'(1) << r_own_q;

  always_comb begin
    w_st_d    = w_st_q;
    w_own_d   = w_own_q;
    w_ptr_d   = w_ptr_q;
    w_cnt_d   = '0;
    aw_addr_d = aw_addr_q;
    aw_len_d  = aw_len_q;
    w_id_d    = w_id_q;
    w_gnt_d   = '0;
    w_trn_d   = 1'b0;
    w_done_d  = '0;
    w_resp_d  = w_resp_q;
    w_ierr    = 1'b0;
    w_pick    = rr_pick(wr_req, w_ptr_q);
    unique case (w_st_q)
      IDLE: if (w_pick[IW]) begin
        w_own_d   = w_pick[IW-1:0];
        aw_addr_d = wr_addr[w_pick[IW-1:0]*addr_width +: addr_width];
        aw_len_d  = wr_len[w_pick[IW-1:0]*8 +: 8];
        w_id_d    = 4'(w_pick[IW-1:0]);
        w_gnt_d   = NUM_REQ'(1) << w_pick[IW-1:0];
        w_st_d    = ISSUE;
      end
      ISSUE: begin
        w_trn_d = 1'b1;
        w_ptr_d = (w_own_q == LAST) ? '0 : w_own_q + 1'b1;
        w_st_d  = WAIT;
      end
      WAIT: begin
        w_cnt_d = w_cnt_q + 1'b1;
        if (wr_rsp_en_d) begin
          w_done_d = w_oh;
          w_resp_d = bresp_d;
          w_ierr   = (bid_d != 4'(w_own_q));
          w_st_d   = IDLE;
        end else if (TIMEOUT != 0 && w_cnt_q == TMAX) begin
          w_done_d = w_oh;
          w_resp_d = 2'b10;
          w_st_d   = IDLE;
        end
      end
      default: w_st_d = IDLE;
    endcase
  end

  always_comb begin
    r_st_d    = r_st_q;
    r_own_d   = r_own_q;
    r_ptr_d   = r_ptr_q;
    r_cnt_d   = '0;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    r_id_d    = r_id_q;
    r_gnt_d   = '0;
    r_trn_d   = 1'b0;
    r_done_d  = '0;
    r_vld_d   = '0;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_ierr    = 1'b0;
    r_pick    = rr_pick(rd_req, r_ptr_q);
    unique case (r_st_q)
      IDLE: if (r_pick[IW]) begin
        r_own_d   = r_pick[IW-1:0];
        ar_addr_d = rd_addr[r_pick[IW-1:0]*addr_width +: addr_width];
        ar_len_d  = rd_len[r_pick[IW-1:0]*8 +: 8];
        r_id_d    = 4'(r_pick[IW-1:0]);
        r_gnt_d   = NUM_REQ'(1) << r_pick[IW-1:0];
        r_st_d    = ISSUE;
      end
      ISSUE: begin
        r_trn_d = 1'b1;
        r_ptr_d = (r_own_q == LAST) ? '0 : r_own_q + 1'b1;
        r_st_d  = WAIT;
      end
      WAIT: begin
        r_cnt_d = r_cnt_q + 1'b1;
        if (rd_rsp_en_d) begin
          // each beat restarts the watchdog window
          r_cnt_d  = '0;
          r_vld_d  = r_oh;
          r_data_d = rdata_d;
          r_resp_d = rresp_d;
          r_ierr   = (rid_d[3:0] != 4'(r_own_q));
          if (r_last_d) begin
            r_done_d = r_oh;
            r_st_d   = IDLE;
          end
        end else if (TIMEOUT != 0 && r_cnt_q == TMAX) begin
          r_done_d = r_oh;
          r_resp_d = 2'b10;
          r_st_d   = IDLE;
        end
      end
      default: r_st_d = IDLE;
    endcase
  end

  assign id_err_d = id_err_q | w_ierr | r_ierr;

  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      w_st_q    <= IDLE;
      r_st_q    <= IDLE;
      w_own_q   <= '0;
      r_own_q   <= '0;
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      aw_len_q  <= '0;
      ar_len_q  <= '0;
      w_id_q    <= '0;
      r_id_q    <= '0;
      w_gnt_q   <= '0;
      r_gnt_q   <= '0;
      w_trn_q   <= 1'b0;
      r_trn_q   <= 1'b0;
      w_done_q  <= '0;
      r_done_q  <= '0;
      r_vld_q   <= '0;
      w_resp_q  <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
      id_err_q  <= 1'b0;
    end else begin
      w_st_q    <= w_st_d;
      r_st_q    <= r_st_d;
      w_own_q   <= w_own_d;
      r_own_q   <= r_own_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      aw_addr_q <= aw_addr_d;
      ar_addr_q <= ar_addr_d;
      aw_len_q  <= aw_len_d;
      ar_len_q  <= ar_len_d;
      w_id_q    <= w_id_d;
      r_id_q    <= r_id_d;
      w_gnt_q   <= w_gnt_d;
      r_gnt_q   <= r_gnt_d;
      w_trn_q   <= w_trn_d;
      r_trn_q   <= r_trn_d;
      w_done_q  <= w_done_d;
      r_done_q  <= r_done_d;
      r_vld_q   <= r_vld_d;
      w_resp_q  <= w_resp_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
      id_err_q  <= id_err_d;
    end
  end

  assign wr_gnt     = w_gnt_q;
  assign wr_done    = w_done_q;
  assign wr_resp    = w_resp_q;
  assign rd_gnt     = r_gnt_q;
  assign rd_valid   = r_vld_q;
  assign rd_data    = r_data_q;
  assign rd_resp    = r_resp_q;
  assign rd_done    = r_done_q;
  assign id_err     = id_err_q;
  assign TXN_ID_W_d = w_id_q;
  assign awaddr_d   = aw_addr_q;
  assign awlen_d    = aw_len_q;
  assign awsize_d   = ASIZE;
  assign awburst_d  = 2'b01;
  assign awlock_d   = 2'b00;
  assign awcache_d  = 2'b00;
  assign awprot_d   = 3'b000;
  assign wr_trn_en  = w_trn_q;
  assign TXN_ID_R_d = r_id_q;
  assign araddr_d   = ar_addr_q;
  assign arlen_d    = ar_len_q;
  assign arsize_d   = ASIZE;
  assign arburst_d  = 2'b01;
  assign arlock_d   = 2'b00;
  assign arcache_d  = 2'b00;
  assign arprot_d   = 3'b000;
  assign rd_trn_en  = r_trn_q;

  // the owner holds its beat until the master consumes it
  assign wdata_d = (w_st_q != IDLE) ? wr_data[w_own_q*data_width +: data_width] : '0;
  assign wstrb_d = (w_st_q != IDLE) ? wr_strb[w_own_q*SW +: SW] : '0;

endmodule

// File: tb/tb_axi_master_txn_scheduler.sv
// Directed bench for axi_master_txn_scheduler (NUM_REQ=2, TIMEOUT=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_master_txn_scheduler;

  logic         AClk, ARst;
  logic [1:0]   wr_req, rd_req;
  logic [63:0]  wr_addr, rd_addr;
  logic [15:0]  wr_len, rd_len;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic [1:0]   wr_gnt, wr_done, wr_resp;
  logic [1:0]   rd_gnt, rd_valid, rd_resp, rd_done;
  logic [63:0]  rd_data;
  logic         id_err;
  logic [3:0]   TXN_ID_W_d, TXN_ID_R_d;
  logic [31:0]  awaddr_d, araddr_d;
  logic [7:0]   awlen_d, arlen_d;
  logic [2:0]   awsize_d, arsize_d, awprot_d, arprot_d;
  logic [1:0]   awburst_d, awlock_d, awcache_d;
  logic [1:0]   arburst_d, arlock_d, arcache_d;
  logic [63:0]  wdata_d;
  logic [7:0]   wstrb_d;
  logic         wr_trn_en, rd_trn_en;
  logic [1:0]   bresp_d, rresp_d;
  logic [3:0]   bid_d;
  logic         wr_rsp_en_d, rd_rsp_en_d, r_last_d;
  logic [63:0]  rdata_d;
  logic [7:0]   rid_d;

  int checks = 0;
  int errors = 0;

  axi_master_txn_scheduler #(
    .addr_width(32), .data_width(64), .NUM_REQ(2), .TIMEOUT(16)
  ) dut (
    .AClk(AClk), .ARst(ARst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_done(rd_done), .id_err(id_err),
    .TXN_ID_W_d(TXN_ID_W_d), .awaddr_d(awaddr_d), .awlen_d(awlen_d),
    .awsize_d(awsize_d), .awburst_d(awburst_d), .awlock_d(awlock_d),
    .awcache_d(awcache_d), .awprot_d(awprot_d),
    .wdata_d(wdata_d), .wstrb_d(wstrb_d), .wr_trn_en(wr_trn_en),
    .TXN_ID_R_d(TXN_ID_R_d), .araddr_d(araddr_d), .arlen_d(arlen_d),
    .arsize_d(arsize_d), .arburst_d(arburst_d), .arlock_d(arlock_d),
    .arcache_d(arcache_d), .arprot_d(arprot_d), .rd_trn_en(rd_trn_en),
    .bresp_d(bresp_d), .bid_d(bid_d), .wr_rsp_en_d(wr_rsp_en_d),
    .rdata_d(rdata_d), .rresp_d(rresp_d), .rid_d(rid_d),
    .rd_rsp_en_d(rd_rsp_en_d), .r_last_d(r_last_d)
  );

  initial AClk = 1'b0;
  always #5 AClk = ~AClk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic clr_in();
    wr_req = '0; rd_req = '0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    wr_data = '0; wr_strb = '0;
    bresp_d = '0; bid_d = '0; wr_rsp_en_d = 1'b0;
    rdata_d = '0; rresp_d = '0; rid_d = '0;
    rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
  endtask

  task automatic rst_dut();
    clr_in();
    ARst = 1'b1;
    tick();
    tick();
    ARst = 1'b0;
  endtask

  initial begin
    logic [1:0] e;
    clr_in();
    ARst = 1'b1;
    #1;
    chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
    chk("rst_wr_trn", 64'(wr_trn_en), 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_id_err", 64'(id_err), 64'd0);
    chk("rst_awaddr", 64'(awaddr_d), 64'd0);
    tick();
    ARst = 1'b0;

    // single write for requester 0
    wr_addr[31:0] = 32'h1000;
    wr_len[7:0]   = 8'd3;
    wr_data[63:0] = 64'hDEAD_BEEF_0000_0001;
    wr_strb[7:0]  = 8'hFF;
    wr_req        = 2'b01;
    tick();
    chk("t1_gnt", 64'(wr_gnt), 64'h1);
    chk("t1_trn_early", 64'(wr_trn_en), 64'd0);
    wr_req = 2'b00;
    tick();
    chk("t1_trn", 64'(wr_trn_en), 64'd1);
    chk("t1_awaddr", 64'(awaddr_d), 64'h1000);
    chk("t1_awlen", 64'(awlen_d), 64'd3);
    chk("t1_idw", 64'(TXN_ID_W_d), 64'd0);
    chk("t1_awsize", 64'(awsize_d), 64'd3);
    chk("t1_awburst", 64'(awburst_d), 64'd1);
    chk("t1_wdata", wdata_d, 64'hDEAD_BEEF_0000_0001);
    chk("t1_wstrb", 64'(wstrb_d), 64'hFF);
    tick();
    chk("t1_trn_one", 64'(wr_trn_en), 64'd0);
    repeat (8) tick();
    chk("t1_no_done", 64'(wr_done), 64'd0);
    wr_rsp_en_d = 1'b1; bresp_d = 2'b00; bid_d = 4'd0;
    tick();
    wr_rsp_en_d = 1'b0;
    chk("t1_done", 64'(wr_done), 64'h1);
    chk("t1_resp", 64'(wr_resp), 64'd0);
    chk("t1_id_err", 64'(id_err), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(wr_done), 64'd0);
    chk("t1_wdata_idle", wdata_d, 64'd0);

    // both requesting: grants alternate 0,1,0,1
    rst_dut();
    wr_addr = {32'h3000, 32'h1000};
    wr_req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      e = 2'(i % 2);
      tick();
      chk("t2_gnt", 64'(wr_gnt), 64'(2'b01 << e));
      tick();
      chk("t2_trn", 64'(wr_trn_en), 64'd1);
      chk("t2_idw", 64'(TXN_ID_W_d), 64'(e));
      chk("t2_awaddr", 64'(awaddr_d), (e == 2'd1) ? 64'h3000 : 64'h1000);
      wr_rsp_en_d = 1'b1; bid_d = 4'(e); bresp_d = 2'b01;
      tick();
      wr_rsp_en_d = 1'b0;
      chk("t2_done", 64'(wr_done), 64'(2'b01 << e));
      chk("t2_resp", 64'(wr_resp), 64'd1);
    end
    wr_req = 2'b00;
    chk("t2_id_err", 64'(id_err), 64'd0);

    // four-beat read for requester 1
    rst_dut();
    rd_addr[63:32] = 32'h2000;
    rd_len[15:8]   = 8'd3;
    rd_req         = 2'b10;
    tick();
    chk("t3_gnt", 64'(rd_gnt), 64'h2);
    rd_req = 2'b00;
    tick();
    chk("t3_trn", 64'(rd_trn_en), 64'd1);
    chk("t3_araddr", 64'(araddr_d), 64'h2000);
    chk("t3_arlen", 64'(arlen_d), 64'd3);
    chk("t3_idr", 64'(TXN_ID_R_d), 64'd1);
    chk("t3_arsize", 64'(arsize_d), 64'd3);
    for (int i = 0; i < 4; i++) begin
      rd_rsp_en_d = 1'b1;
      rdata_d     = 64'hA + 64'(i);
      rid_d       = 8'd1;
      rresp_d     = 2'b00;
      r_last_d    = (i == 3);
      tick();
      chk("t3_valid", 64'(rd_valid), 64'h2);
      chk("t3_data", rd_data, 64'hA + 64'(i));
      chk("t3_done", 64'(rd_done), (i == 3) ? 64'h2 : 64'h0);
    end
    rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    tick();
    chk("t3_valid_end", 64'(rd_valid), 64'd0);
    chk("t3_done_end", 64'(rd_done), 64'd0);
    chk("t3_id_err", 64'(id_err), 64'd0);

    // concurrent write (req0) and read (req1)
    rst_dut();
    wr_req = 2'b01;
    rd_req = 2'b10;
    tick();
    chk("t4_gnts", 64'({wr_gnt, rd_gnt}), 64'h6);
    wr_req = 2'b00;
    rd_req = 2'b00;
    tick();
    chk("t4_trns", 64'({wr_trn_en, rd_trn_en}), 64'h3);
    wr_rsp_en_d = 1'b1; bid_d = 4'd0; bresp_d = 2'b00;
    tick();
    wr_rsp_en_d = 1'b0;
    chk("t4_wr_done", 64'(wr_done), 64'h1);
    chk("t4_rd_busy", 64'(rd_done), 64'd0);
    rd_rsp_en_d = 1'b1; rdata_d = 64'h55; rid_d = 8'd1;
    r_last_d = 1'b1; rresp_d = 2'b01;
    tick();
    rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    chk("t4_rd_done", 64'(rd_done), 64'h2);
    chk("t4_rd_data", rd_data, 64'h55);
    chk("t4_rd_resp", 64'(rd_resp), 64'd1);
    chk("t4_wr_quiet", 64'(wr_done), 64'd0);

    // write watchdog
    rst_dut();
    wr_req = 2'b01;
    tick();
    wr_req = 2'b00;
    tick();
    chk("t5_trn", 64'(wr_trn_en), 64'd1);
    repeat (15) tick();
    chk("t5_not_yet", 64'(wr_done), 64'd0);
    tick();
    chk("t5_to_done", 64'(wr_done), 64'h1);
    chk("t5_to_resp", 64'(wr_resp), 64'h2);
    wr_rsp_en_d = 1'b1; bid_d = 4'd0; bresp_d = 2'b00;
    tick();
    wr_rsp_en_d = 1'b0;
    chk("t5_late", 64'(wr_done), 64'd0);
    tick();
    chk("t5_late2", 64'(wr_done), 64'd0);

    // ID mismatch, then reset during read WAIT
    rst_dut();
    wr_req = 2'b01;
    tick();
    wr_req = 2'b00;
    tick();
    wr_rsp_en_d = 1'b1; bid_d = 4'd1; bresp_d = 2'b00;
    tick();
    wr_rsp_en_d = 1'b0; bid_d = 4'd0;
    chk("t6_done", 64'(wr_done), 64'h1);
    chk("t6_id_err", 64'(id_err), 64'd1);
    repeat (5) tick();
    chk("t6_id_sticky", 64'(id_err), 64'd1);
    rd_addr[31:0] = 32'h4000;
    rd_req = 2'b01;
    tick();
    rd_req = 2'b00;
    tick();
    chk("t6_rd_trn", 64'(rd_trn_en), 64'd1);
    chk("t6_araddr", 64'(araddr_d), 64'h4000);
    tick();
    tick();
    #2;
    ARst = 1'b1;
    #1;
    chk("t6_rst_id_err", 64'(id_err), 64'd0);
    chk("t6_rst_araddr", 64'(araddr_d), 64'd0);
    chk("t6_rst_idr", 64'(TXN_ID_R_d), 64'd0);
    chk("t6_rst_done", 64'(rd_done), 64'd0);
    tick();
    chk("t6_rst_hold", 64'(rd_done), 64'd0);
    ARst = 1'b0;
    tick();
    chk("t6_after_done", 64'(rd_done), 64'd0);
    chk("t6_after_trn", 64'(rd_trn_en), 64'd0);
    chk("t6_after_gnt", 64'(rd_gnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
